cmp_seq: RTL and testbench
==========================

CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits compared per cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise); N = WIDTH/CHUNK.
REQ-003 SHALL have parameter EARLY_EXIT, default 0: when 1, finish on the first differing chunk.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1: rising-edge clock.
REQ-006 rst  input  1: asynchronous active-high reset.
REQ-007 in_valid  input  1: request valid.
REQ-008 in_ready  output  1: request accepted when in_valid && in_ready at a rising edge.
REQ-009 operand_a  input  WIDTH: first operand.
REQ-010 operand_b  input  WIDTH: second operand.
REQ-011 cmp_op  input  cmp_op_t: operation select.
REQ-012 out_valid  output  1: result valid.
REQ-013 out_ready  input  1: result consumed when out_valid && out_ready at a rising edge.
REQ-014 result  output  1: comparison result.
REQ-015 minmax  output  WIDTH: selected operand for MIN/MAX operations; 0 otherwise.

Function
REQ-016 SHALL support these operations:
- CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU: boolean result.
- CMP_MIN, CMP_MAX (signed), CMP_MINU, CMP_MAXU (unsigned): result = (a selected), minmax = selected operand.
- Any other code: result = 0, minmax = 0, normal latency.
REQ-017 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready = 1.
- RUN and DONE: in_ready = 0.
REQ-018 On an accept edge SHALL latch operands and op, clear the chunk counter, and enter RUN.
REQ-019 In RUN, edge k (k = 0..N-1) SHALL compare chunk N-1-k, MSB chunk first.
- The MSB chunk is compared signed for signed ops; all other chunks are compared unsigned.
REQ-020 Once a differing chunk is found, lt/eq SHALL be frozen; later chunks do not alter them.
REQ-021 Latency: DONE entered at edge N after acceptance (out_valid high the cycle after).
- With EARLY_EXIT = 1: at the edge processing the first differing chunk.
- Equal operands always take N.
REQ-022 In DONE, out_valid = 1 and result/minmax SHALL be held stable until the out_ready edge, then return to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle as the output handshake; there is at least one IDLE cycle between requests.
REQ-024 in_valid and operand changes outside IDLE SHALL be ignored.
REQ-025 Tie on MIN/MAX (a == b) SHALL select operand_a.
REQ-026 CHUNK == WIDTH SHALL be legal: single-cycle RUN.

Reset
REQ-027 On rst asserted, immediately (asynchronously), SHALL set:
- state = IDLE, counter = 0;
- out_valid = 0, result = 0, minmax = 0;
- latched operands = 0.
REQ-028 in_ready SHALL be 1 whenever in IDLE, including during reset.
REQ-029 Reset mid-RUN or mid-DONE SHALL abort the operation and discard it, with no output handshake.

Structure
REQ-030 cmp_op_t SHALL be extended in the shared types package with CMP_MIN, CMP_MAX, CMP_MINU, CMP_MAXU; the existing encodings are unchanged.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 One sub-module, cmp_chunk, SHALL compute per-chunk lt/eq with a signed-mode input; it is purely combinational.

Verification (WIDTH=32, CHUNK=8)
REQ-033 a=0xFFFFFFFF, b=0x00000001, CMP_LT -> result=1; CMP_LTU -> result=0.
- EARLY_EXIT=0: out_valid 4 cycles after accept.
- EARLY_EXIT=1: 1 cycle after accept.
REQ-034 a=b=0x12345678, CMP_EQ -> result=1 after 4 cycles with either EARLY_EXIT; CMP_NE -> 0.
REQ-035 a=0x80000000, b=0x7FFFFFFF:
- CMP_MAX -> minmax=0x7FFFFFFF, result=0.
- CMP_MAXU -> minmax=0x80000000, result=1.
- CMP_MIN -> minmax=0x80000000.
REQ-036 a=0x00FF0001, b=0x00FF0002, CMP_LTU with out_ready held low 3 cycles:
- result=1 and out_valid held throughout; in_ready=0; operand changes ignored.
- Return to IDLE after the out_ready edge.
REQ-037 rst pulsed during RUN edge 2 -> out_valid=0, result=0, minmax=0 immediately; in_ready=1; the next request completes normally.
REQ-038 Illegal cmp_op encoding -> result=0, minmax=0, out_valid after 4 cycles.

Source files
------------

// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: shared types for the chunked sequential comparator.
//   cmp_op_t      - operation select; codes 10..15 are illegal and yield 0.
//   is_signed_op  - true for operations whose MSB chunk compares signed.
package cmp_seq_pkg;

   typedef enum logic [3:0] {
      CMP_EQ   = 4'd0,
      CMP_NE   = 4'd1,
      CMP_LT   = 4'd2,
      CMP_GE   = 4'd3,
      CMP_LTU  = 4'd4,
      CMP_GEU  = 4'd5,
      CMP_MIN  = 4'd6,
      CMP_MAX  = 4'd7,
      CMP_MINU = 4'd8,
      CMP_MAXU = 4'd9
   } cmp_op_t;

   function automatic logic is_signed_op(input cmp_op_t op);
      return (op == CMP_LT) || (op == CMP_GE) || (op == CMP_MIN) || (op == CMP_MAX);
   endfunction

endpackage

// File: rtl/cmp_seq_chunk.sv
// cmp_chunk: combinational compare of one CHUNK-wide slice.
//   a_i, b_i    - operand slices
//   signed_i    - 1: compare as two's complement, 0: unsigned
//   lt_o        - a_i < b_i in the selected mode
//   eq_o        - a_i == b_i
module cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             signed_i,
   output logic             lt_o,
   output logic             eq_o
);

   always_comb begin
      if (signed_i) lt_o = $signed(a_i) < $signed(b_i);
      else          lt_o = a_i < b_i;
      eq_o = (a_i == b_i);
   end

endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle comparator, CHUNK bits per cycle, MSB chunk first.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - request handshake (ready only in IDLE)
//   operand_a/b, cmp_op - request payload, latched on accept
//   out_valid/out_ready - result handshake (valid only in DONE)
//   result, minmax      - boolean result; selected operand for MIN/MAX else 0
module cmp_seq
   import cmp_seq_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int CHUNK      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  cmp_op_t          cmp_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic [WIDTH-1:0] minmax
);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("cmp_seq: WIDTH must be a multiple of CHUNK");
   end

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   cmp_op_t            op_q, op_d;
   logic               lt_q, lt_d, eq_q, eq_d;
   logic               result_q, result_d;
   logic [WIDTH-1:0]   minmax_q, minmax_d;

   int                 sel;
   logic [CHUNK-1:0]   ca, cb;
   logic               c_signed, c_lt, c_eq;

   // Final result from the frozen lt/eq; MIN/MAX ties select operand a.
   function automatic logic [WIDTH:0] finish_op(input cmp_op_t op, input logic lt,
                                                input logic eq, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic             res;
      logic [WIDTH-1:0] mm;
      res = 1'b0;
      mm  = '0;
      case (op)
         CMP_EQ:             res = eq;
         CMP_NE:             res = !eq;
         CMP_LT, CMP_LTU:    res = lt;
         CMP_GE, CMP_GEU:    res = !lt;
         CMP_MIN, CMP_MINU: begin
            res = lt | eq;
            mm  = res ? a : b;
         end
         CMP_MAX, CMP_MAXU: begin
            res = !lt;
            mm  = res ? a : b;
         end
         default: ;
      endcase
      return {res, mm};
   endfunction

   // Counter k addresses chunk N-1-k; only the top chunk carries the sign.
   assign sel      = (N - 1) - int'(cnt_q);
   assign ca       = a_q[sel*CHUNK +: CHUNK];
   assign cb       = b_q[sel*CHUNK +: CHUNK];
   assign c_signed = is_signed_op(op_q) && (sel == N - 1);

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i      (ca),
      .b_i      (cb),
      .signed_i (c_signed),
      .lt_o     (c_lt),
      .eq_o     (c_eq)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      result_d = result_q;
      minmax_d = minmax_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = operand_a;
               b_d     = operand_b;
               op_d    = cmp_op;
               cnt_d   = '0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // eq_q still set means no difference yet; otherwise lt/eq stay frozen.
            if (eq_q) begin
               lt_d = c_lt;
               eq_d = c_eq;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q == LAST) || ((EARLY_EXIT != 0) && eq_q && !c_eq)) begin
               state_d              = S_DONE;
               {result_d, minmax_d} = finish_op(op_q, lt_d, eq_d, a_q, b_q);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= CMP_EQ;
         lt_q     <= 1'b0;
         eq_q     <= 1'b1;
         result_q <= 1'b0;
         minmax_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         result_q <= result_d;
         minmax_q <= minmax_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign minmax    = minmax_q;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed table-driven bench for cmp_seq (WIDTH=32, CHUNK=8).
// Two instances run side by side: u0 with EARLY_EXIT=0, u1 with EARLY_EXIT=1.
module tb_cmp_seq;
   import cmp_seq_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   cmp_op_t      op = CMP_EQ;

   logic         ir0, ov0, r0, ir1, ov1, r1;
   logic [W-1:0] mm0, mm1;

   always #5 clk = ~clk;

   cmp_seq #(.WIDTH(W), .CHUNK(8), .EARLY_EXIT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .operand_a(a), .operand_b(b), .cmp_op(op),
      .out_valid(ov0), .out_ready(out_ready), .result(r0), .minmax(mm0)
   );

   cmp_seq #(.WIDTH(W), .CHUNK(8), .EARLY_EXIT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .operand_a(a), .operand_b(b), .cmp_op(op),
      .out_valid(ov1), .out_ready(out_ready), .result(r1), .minmax(mm1)
   );

   typedef struct {
      cmp_op_t      op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         res;
      logic [W-1:0] mm;
      int           lat0;
      int           lat1;
   } vec_t;

   vec_t vecs [16];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int idx);
      int           lat0 = 99;
      int           lat1 = 99;
      logic         res0 = 1'b0;
      logic         res1 = 1'b0;
      logic [W-1:0] m0 = '0;
      logic [W-1:0] m1 = '0;
      @(negedge clk);
      a = v.a; b = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (ov0 && lat0 == 99) begin lat0 = c; res0 = r0; m0 = mm0; end
         if (ov1 && lat1 == 99) begin lat1 = c; res1 = r1; m1 = mm1; end
         if (lat0 != 99 && lat1 != 99) break;
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d ee0 result", idx), 64'(res0), 64'(v.res));
      check($sformatf("v%0d ee0 minmax", idx), 64'(m0), 64'(v.mm));
      check($sformatf("v%0d ee0 latency", idx), 64'(lat0), 64'(v.lat0));
      check($sformatf("v%0d ee1 result", idx), 64'(res1), 64'(v.res));
      check($sformatf("v%0d ee1 minmax", idx), 64'(m1), 64'(v.mm));
      check($sformatf("v%0d ee1 latency", idx), 64'(lat1), 64'(v.lat1));
      check($sformatf("v%0d idle ready", idx), {62'd0, ir0, ir1}, 64'd3);
   endtask

   initial begin
      vecs[0]  = '{CMP_LT,   32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h0,        4, 1};
      vecs[1]  = '{CMP_LTU,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0,        4, 1};
      vecs[2]  = '{CMP_EQ,   32'h12345678, 32'h12345678, 1'b1, 32'h0,        4, 4};
      vecs[3]  = '{CMP_NE,   32'h12345678, 32'h12345678, 1'b0, 32'h0,        4, 4};
      vecs[4]  = '{CMP_MAX,  32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 4, 1};
      vecs[5]  = '{CMP_MAXU, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h80000000, 4, 1};
      vecs[6]  = '{CMP_MIN,  32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h80000000, 4, 1};
      vecs[7]  = '{CMP_MINU, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 4, 1};
      vecs[8]  = '{cmp_op_t'(4'hC), 32'h00000001, 32'h00000002, 1'b0, 32'h0, 4, 4};
      vecs[9]  = '{CMP_LTU,  32'h00FF0001, 32'h00FF0002, 1'b1, 32'h0,        4, 4};
      vecs[10] = '{CMP_GE,   32'h00000005, 32'h00000005, 1'b1, 32'h0,        4, 4};
      vecs[11] = '{CMP_MIN,  32'hAAAA5555, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 4, 4};
      vecs[12] = '{CMP_GEU,  32'h00010000, 32'h0000FFFF, 1'b1, 32'h0,        4, 2};
      vecs[13] = '{CMP_LT,   32'h7F000000, 32'h80000000, 1'b0, 32'h0,        4, 1};
      vecs[14] = '{CMP_LT,   32'h00000080, 32'h00000001, 1'b0, 32'h0,        4, 4};
      vecs[15] = '{CMP_LTU,  32'h01000000, 32'h00FFFFFF, 1'b0, 32'h0,        4, 1};

      // Reset state, observed while reset is still asserted.
      #1 rst = 1'b1;
      #2;
      check("reset in_ready", {62'd0, ir0, ir1}, 64'd3);
      check("reset out_valid", {62'd0, ov0, ov1}, 64'd0);
      check("reset result", {62'd0, r0, r1}, 64'd0);
      check("reset minmax", {mm0, mm1}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 16; i++) run(vecs[i], i);

      // Result held while out_ready is low; busy instances ignore new requests.
      @(negedge clk);
      a = 32'h00FF0001; b = 32'h00FF0002; op = CMP_LTU; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("hold first valid", {62'd0, ov0, ov1}, 64'd3);
      check("hold first result", {62'd0, r0, r1}, 64'd3);
      for (int c = 0; c < 3; c++) begin
         a = $urandom; b = '0; op = CMP_EQ; in_valid = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("hold%0d valid", c), {62'd0, ov0, ov1}, 64'd3);
         check($sformatf("hold%0d result", c), {62'd0, r0, r1}, 64'd3);
         check($sformatf("hold%0d minmax", c), {mm0, mm1}, 64'd0);
         check($sformatf("hold%0d in_ready", c), {62'd0, ir0, ir1}, 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold release valid", {62'd0, ov0, ov1}, 64'd0);
      check("hold release ready", {62'd0, ir0, ir1}, 64'd3);

      // Asynchronous reset with u0 mid-RUN and u1 already in DONE.
      @(negedge clk);
      a = 32'h80000000; b = 32'h7FFFFFFF; op = CMP_MAXU; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("pre-reset u1 done", {62'd0, ov1, r1}, 64'd3);
      check("pre-reset u0 busy", {62'd0, ov0, ir0}, 64'd0);
      rst = 1'b1;
      #1;
      check("abort out_valid", {62'd0, ov0, ov1}, 64'd0);
      check("abort result", {62'd0, r0, r1}, 64'd0);
      check("abort minmax", {mm0, mm1}, 64'd0);
      check("abort in_ready", {62'd0, ir0, ir1}, 64'd3);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      run(vecs[5], 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
